// File: rtl/core_jtag_mon_mem_ctrl.sv
// ---------------------------------------------------------------------------
// core_jtag_mon_mem_ctrl
//
// Bridges the JTAG debug monitor commands onto an Avalon-MM master port.
// A command pulse from the JTAG sysclk stage loads the monitor address and
// data registers, or starts a single-word read or write transfer. Each
// accepted transfer post-increments the word address. A transfer that stays
// stalled by waitrequest for TIMEOUT cycles is abandoned and flagged.
//
// Ports
//   clk, reset               : clock and asynchronous active-high reset
//   jdo[37:0]                : command/data word from the JTAG sysclk stage
//   take_action_ocimem_a     : load address, read if jdo[34] is set
//   take_action_ocimem_b     : write jdo[34:3] at the current address
//   take_no_action_ocimem_a  : read at the current address
//   avm_*                    : Avalon-MM master (word-aligned byte address)
//   MonDReg, MonAReg         : monitor data / word-address registers
//   monitor_ready            : idle with the last transfer complete
//   monitor_error            : sticky error (collision or timeout)
// ---------------------------------------------------------------------------
module core_jtag_mon_mem_ctrl #(
    parameter int AW      = 9,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [37:0]   jdo,
    input  logic          take_action_ocimem_a,
    input  logic          take_action_ocimem_b,
    input  logic          take_no_action_ocimem_a,
    output logic [AW+1:0] avm_address,
    output logic          avm_read,
    output logic          avm_write,
    output logic [31:0]   avm_writedata,
    output logic [3:0]    avm_byteenable,
    input  logic [31:0]   avm_readdata,
    input  logic          avm_waitrequest,
    output logic [31:0]   MonDReg,
    output logic [AW-1:0] MonAReg,
    output logic          monitor_ready,
    output logic          monitor_error
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_WR   = 2'd2;

    // Stall count value seen during the TIMEOUT-th stalled cycle; a stall in
    // that cycle is the last one tolerated.
    localparam logic [7:0] STALL_LAST = 8'(TIMEOUT - 1);

    logic [1:0]    state_q, state_d;
    logic [7:0]    stall_q, stall_d;
    logic [31:0]   mon_d_q, mon_d_d;
    logic [AW-1:0] mon_a_q, mon_a_d;
    logic          ready_q, ready_d;
    logic          error_q, error_d;
    logic          any_cmd;

    // Bits of jdo not carried by any command field.
    logic jdo_unused;
    assign jdo_unused = ^{jdo[37:35], jdo[2:0]};

    assign any_cmd = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;

    always_comb begin
        state_d = state_q;
        stall_d = stall_q;
        mon_d_d = mon_d_q;
        mon_a_d = mon_a_q;
        ready_d = ready_q;
        error_d = error_q;
        case (state_q)
            S_IDLE: begin
                stall_d = 8'd0;
                if (take_action_ocimem_a) begin
                    mon_a_d = jdo[AW+16:17];
                    error_d = 1'b0;
                    if (jdo[34]) begin
                        state_d = S_RD;
                        ready_d = 1'b0;
                    end
                end else if (take_action_ocimem_b) begin
                    mon_d_d = jdo[34:3];
                    state_d = S_WR;
                    ready_d = 1'b0;
                end else if (take_no_action_ocimem_a) begin
                    state_d = S_RD;
                    ready_d = 1'b0;
                end
            end
            S_RD, S_WR: begin
                // Commands while busy are dropped but remembered as an error.
                if (any_cmd) begin
                    error_d = 1'b1;
                end
                if (!avm_waitrequest) begin
                    if (state_q == S_RD) begin
                        mon_d_d = avm_readdata;
                    end
                    mon_a_d = mon_a_q + 1'b1;
                    state_d = S_IDLE;
                    ready_d = 1'b1;
                end else begin
                    stall_d = stall_q + 8'd1;
                    if (stall_q == STALL_LAST) begin
                        if (state_q == S_RD) begin
                            mon_d_d = 32'hDEADBEEF;
                        end
                        error_d = 1'b1;
                        ready_d = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            stall_q <= 8'd0;
            mon_d_q <= 32'd0;
            mon_a_q <= '0;
            ready_q <= 1'b1;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            stall_q <= stall_d;
            mon_d_q <= mon_d_d;
            mon_a_q <= mon_a_d;
            ready_q <= ready_d;
            error_q <= error_d;
        end
    end

    // Strobes decode straight from the state register so reset drops them
    // without waiting for a clock edge.
    assign avm_read       = (state_q == S_RD);
    assign avm_write      = (state_q == S_WR);
    assign avm_address    = {mon_a_q, 2'b00};
    assign avm_writedata  = mon_d_q;
    assign avm_byteenable = 4'hF;
    assign MonDReg        = mon_d_q;
    assign MonAReg        = mon_a_q;
    assign monitor_ready  = ready_q;
    assign monitor_error  = error_q;

endmodule
